// File: rtl/stack_pkg.sv
// Shared opcode map, per-opcode stack requirements and sequencer state encoding.
package stack_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_PUSHI = 4'd1;
    localparam logic [3:0] OP_POP   = 4'd2;
    localparam logic [3:0] OP_DUP   = 4'd3;
    localparam logic [3:0] OP_OVER  = 4'd4;
    localparam logic [3:0] OP_SWAP  = 4'd5;
    localparam logic [3:0] OP_ADD   = 4'd6;
    localparam logic [3:0] OP_SUB   = 4'd7;
    localparam logic [3:0] OP_AND   = 4'd8;
    localparam logic [3:0] OP_OR    = 4'd9;
    localparam logic [3:0] OP_XOR   = 4'd10;
    localparam logic [3:0] OP_NOT   = 4'd11;
    localparam logic [3:0] OP_INC   = 4'd12;

    typedef enum logic {
        ST_IDLE,
        ST_SWAP2
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] need;   // minimum depth before the op may execute
        logic       inc;    // depth grows by one
        logic       dec;    // depth shrinks by one
    } op_info_t;

    function automatic op_info_t op_info(input logic [3:0] op);
        op_info_t r;
        r = '{legal: 1'b1, need: 2'd0, inc: 1'b0, dec: 1'b0};
        case (op)
            OP_NOP:   ;
            OP_PUSHI: r.inc = 1'b1;
            OP_POP:   begin r.need = 2'd1; r.dec = 1'b1; end
            OP_DUP:   begin r.need = 2'd1; r.inc = 1'b1; end
            OP_OVER:  begin r.need = 2'd2; r.inc = 1'b1; end
            OP_SWAP:  r.need = 2'd2;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                      begin r.need = 2'd2; r.dec = 1'b1; end
            OP_NOT, OP_INC:
                      r.need = 2'd1;
            default:  r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational ALU for stack ops: a is the top word, b the word beneath it.
// Zero latency, no flow control; result is don't-care (zero) for non-ALU opcodes.
module stack_alu
    import stack_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = b + a;
            OP_SUB:  result = b - a;
            OP_AND:  result = b & a;
            OP_OR:   result = b | a;
            OP_XOR:  result = b ^ a;
            OP_NOT:  result = ~a;
            OP_INC:  result = a + DW'(1);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/stack_seq.sv
// Operand-stack sequencer: one opcode per accept, SWAP takes two cycles (op_ready low in the 2nd).
// Controls are combinational at accept; result visible on s_qtop next cycle; tracks depth and sticky err.
module stack_seq
    import stack_pkg::*;
#(
    parameter int N  = 8,
    parameter int DW = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [3:0]             op,
    input  logic [DW-1:0]          imm,
    output logic                   s_load,
    output logic                   s_push,
    output logic                   s_pop,
    output logic [DW-1:0]          s_d,
    input  logic [DW-1:0]          s_qtop,
    input  logic [DW-1:0]          s_qnext,
    output logic [$clog2(N+1)-1:0] depth,
    output logic                   err,
    output logic [DW-1:0]          top
);

    localparam int DEPTH_W = $clog2(N+1);

    state_t               state_q, state_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 err_q, err_d;
    logic [DW-1:0]        swap_hold_q, swap_hold_d;

    op_info_t             info;
    logic                 accept;
    logic                 fault;
    logic [DW-1:0]        alu_result;

    stack_alu #(.DW(DW)) u_alu (
        .op     (op),
        .a      (s_qtop),
        .b      (s_qnext),
        .result (alu_result)
    );

    assign info   = op_info(op);
    assign accept = op_valid && op_ready;
    assign fault  = !info.legal
                 || (depth_q < DEPTH_W'(info.need))
                 || (info.inc && depth_q == DEPTH_W'(N));

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        err_d       = err_q;
        swap_hold_d = swap_hold_q;
        s_load      = 1'b0;
        s_push      = 1'b0;
        s_pop       = 1'b0;
        s_d         = '0;
        op_ready    = (state_q == ST_IDLE) && !reset;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (fault) begin
                        err_d = 1'b1;
                    end else begin
                        if (info.inc)      depth_d = depth_q + DEPTH_W'(1);
                        else if (info.dec) depth_d = depth_q - DEPTH_W'(1);
                        case (op)
                            OP_PUSHI: begin s_load = 1'b1; s_push = 1'b1; s_d = imm; end
                            OP_POP:   s_pop = 1'b1;
                            OP_DUP:   s_push = 1'b1;
                            OP_OVER:  begin s_load = 1'b1; s_push = 1'b1; s_d = s_qnext; end
                            OP_SWAP: begin
                                // Drop the old top onto the second slot, then re-push the saved second word.
                                s_load      = 1'b1;
                                s_pop       = 1'b1;
                                s_d         = s_qtop;
                                swap_hold_d = s_qnext;
                                state_d     = ST_SWAP2;
                            end
                            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                                s_load = 1'b1; s_pop = 1'b1; s_d = alu_result;
                            end
                            OP_NOT, OP_INC: begin s_load = 1'b1; s_d = alu_result; end
                            default: ;
                        endcase
                    end
                end
            end
            ST_SWAP2: begin
                if (!reset) begin
                    s_load = 1'b1;
                    s_push = 1'b1;
                    s_d    = swap_hold_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            depth_q     <= '0;
            err_q       <= 1'b0;
            swap_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            err_q       <= err_d;
            swap_hold_q <= swap_hold_d;
        end
    end

    assign depth = depth_q;
    assign err   = err_q;
    assign top   = s_qtop;

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq driving a behavioural model of the attached operand stack.
module tb_stack_seq;

    localparam int N  = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic [3:0]    op;
    logic [DW-1:0] imm;
    logic          s_load, s_push, s_pop;
    logic [DW-1:0] s_d, s_qtop, s_qnext, top;
    logic [3:0]    depth;
    logic          err;

    int n_vec  = 0;
    int n_miss = 0;
    logic [2:0] last_ctl;

    always #5 clk = ~clk;

    stack_seq #(.N(N), .DW(DW)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op(op), .imm(imm), .s_load(s_load), .s_push(s_push), .s_pop(s_pop),
        .s_d(s_d), .s_qtop(s_qtop), .s_qnext(s_qnext), .depth(depth),
        .err(err), .top(top)
    );

    // Operand stack model with an active-low reset shared with the sequencer.
    logic rst_n;
    logic [DW-1:0] stk [N];
    assign rst_n   = ~reset;
    assign s_qtop  = stk[0];
    assign s_qnext = stk[1];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) stk[i] <= '0;
        end else if (s_load && s_push) begin
            stk[0] <= s_d;
            for (int i = 1; i < N; i++) stk[i] <= stk[i-1];
        end else if (s_push) begin
            for (int i = 1; i < N; i++) stk[i] <= stk[i-1];
        end else if (s_load && s_pop) begin
            stk[0] <= s_d;
            for (int i = 1; i < N-1; i++) stk[i] <= stk[i+1];
            stk[N-1] <= '0;
        end else if (s_pop) begin
            for (int i = 0; i < N-1; i++) stk[i] <= stk[i+1];
            stk[N-1] <= '0;
        end else if (s_load) begin
            stk[0] <= s_d;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    // Present one opcode; captures stack controls just before the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [DW-1:0] v);
        int budget;
        @(negedge clk);
        op_valid = 1'b1;
        op       = o;
        imm      = v;
        budget   = 0;
        while (!op_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!op_ready) begin
            chk("op_ready_timeout", 32'd0, 32'd1);
            op_valid = 1'b0;
            return;
        end
        #1 last_ctl = {s_load, s_push, s_pop};
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        op_valid = 1'b0;
        op       = 4'd0;
        imm      = '0;
        last_ctl = 3'b000;
        #12;
        chk("rst_op_ready", {31'd0, op_ready}, 32'd0);
        chk("rst_ctl", {29'd0, s_load, s_push, s_pop}, 32'd0);
        chk("rst_s_d", {16'd0, s_d}, 32'd0);
        do_reset();
        chk("rst_depth", {28'd0, depth}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("idle_ready", {31'd0, op_ready}, 32'd1);

        // Subtraction order and wrap
        issue(4'd1, 16'd5);
        issue(4'd1, 16'd3);
        chk("pushi_ctl", {29'd0, last_ctl}, 32'b110);
        issue(4'd7, 16'd0);
        chk("sub_ctl", {29'd0, last_ctl}, 32'b101);
        chk("sub_top", {16'd0, top}, 32'd2);
        chk("sub_depth", {28'd0, depth}, 32'd1);
        chk("sub_err", {31'd0, err}, 32'd0);
        issue(4'd1, 16'd0);
        issue(4'd1, 16'd1);
        issue(4'd7, 16'd0);
        chk("sub_wrap", {16'd0, top}, 32'h0000FFFF);
        issue(4'd0, 16'd0);
        chk("nop_depth", {28'd0, depth}, 32'd2);

        // SWAP
        do_reset();
        issue(4'd1, 16'h1234);
        issue(4'd1, 16'hABCD);
        issue(4'd5, 16'd0);
        chk("swap_c1_ctl", {29'd0, last_ctl}, 32'b101);
        chk("swap_busy", {31'd0, op_ready}, 32'd0);
        chk("swap_c2_ctl", {29'd0, s_load, s_push, s_pop}, 32'b110);
        @(posedge clk); #1;
        chk("swap_ready", {31'd0, op_ready}, 32'd1);
        chk("swap_top", {16'd0, top}, 32'h1234);
        chk("swap_next", {16'd0, s_qnext}, 32'hABCD);
        chk("swap_depth", {28'd0, depth}, 32'd2);

        // DUP / OVER / ADD
        do_reset();
        issue(4'd1, 16'd7);
        issue(4'd3, 16'd0);
        issue(4'd4, 16'd0);
        chk("over_depth", {28'd0, depth}, 32'd3);
        chk("over_top", {16'd0, top}, 32'd7);
        chk("over_next", {16'd0, s_qnext}, 32'd7);
        issue(4'd6, 16'd0);
        issue(4'd6, 16'd0);
        chk("add_top", {16'd0, top}, 32'd21);
        chk("add_depth", {28'd0, depth}, 32'd1);

        // Overflow then drain
        do_reset();
        for (int i = 0; i < 8; i++) issue(4'd1, 16'(i + 1));
        chk("full_depth", {28'd0, depth}, 32'd8);
        chk("full_err", {31'd0, err}, 32'd0);
        issue(4'd1, 16'h00EE);
        chk("ovf_ctl", {29'd0, last_ctl}, 32'd0);
        chk("ovf_depth", {28'd0, depth}, 32'd8);
        chk("ovf_err", {31'd0, err}, 32'd1);
        chk("ovf_top", {16'd0, top}, 32'd8);
        for (int i = 0; i < 8; i++) issue(4'd2, 16'd0);
        chk("drain_depth", {28'd0, depth}, 32'd0);
        chk("drain_err", {31'd0, err}, 32'd1);

        // Underflow and illegal opcode
        do_reset();
        issue(4'd2, 16'd0);
        chk("unf_ctl", {29'd0, last_ctl}, 32'd0);
        chk("unf_err", {31'd0, err}, 32'd1);
        chk("unf_depth", {28'd0, depth}, 32'd0);
        do_reset();
        issue(4'd1, 16'h0055);
        issue(4'd4, 16'd0);
        chk("over_unf_ctl", {29'd0, last_ctl}, 32'd0);
        chk("over_unf_err", {31'd0, err}, 32'd1);
        chk("over_unf_depth", {28'd0, depth}, 32'd1);
        do_reset();
        issue(4'd1, 16'h0055);
        issue(4'd14, 16'd0);
        chk("ill_ctl", {29'd0, last_ctl}, 32'd0);
        chk("ill_err", {31'd0, err}, 32'd1);
        chk("ill_top", {16'd0, top}, 32'h0055);
        chk("ill_depth", {28'd0, depth}, 32'd1);
        issue(4'd12, 16'd0);
        chk("post_err_inc", {16'd0, top}, 32'h0056);
        chk("post_err_sticky", {31'd0, err}, 32'd1);

        // Reset in the middle of a swap
        do_reset();
        issue(4'd1, 16'd1);
        issue(4'd1, 16'd2);
        issue(4'd5, 16'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, op_ready}, 32'd0);
        chk("mid_rst_ctl", {29'd0, s_load, s_push, s_pop}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready2", {31'd0, op_ready}, 32'd1);
        chk("mid_rst_depth", {28'd0, depth}, 32'd0);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        chk("mid_rst_stack", {s_qnext, top}, 32'd0);
        issue(4'd1, 16'hFFFF);
        issue(4'd12, 16'd0);
        chk("inc_wrap", {16'd0, top}, 32'd0);
        chk("inc_depth", {28'd0, depth}, 32'd1);

        // Logic ops
        do_reset();
        issue(4'd1, 16'hF0F0);
        issue(4'd1, 16'h0FF0);
        issue(4'd8, 16'd0);
        chk("and_top", {16'd0, top}, 32'h00F0);
        issue(4'd1, 16'h0F00);
        issue(4'd9, 16'd0);
        chk("or_top", {16'd0, top}, 32'h0FF0);
        issue(4'd1, 16'h00FF);
        issue(4'd10, 16'd0);
        chk("xor_top", {16'd0, top}, 32'h0F0F);
        issue(4'd11, 16'd0);
        chk("not_ctl", {29'd0, last_ctl}, 32'b100);
        chk("not_top", {16'd0, top}, 32'hF0F0);
        chk("logic_depth", {28'd0, depth}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
